astable555_oscillator: RTL and testbench
========================================

// Module: astable555_oscillator
// PURPOSE
//  Behavioural discrete model of the 555 astable that receives v_control from the walk-enable RC network.
//  Regenerates square_wave, which feeds back into that network to close the loop.
//  Runs once per audio_clk_en. The timing-capacitor voltage is stepped as a first-order RC toward VCC or GND.
//  Thresholds are derived from the control-voltage pin.
// PARAMETERS
//  K_CHARGE     16'd120    per-sample RC step fraction while charging (x/65536), from (RA+RB)*C and fs
//  K_DISCHARGE  16'd240    per-sample RC step fraction while discharging or held (x/65536), from RB*C and fs
//  WALK_TH      16'sd2294  reset-pin threshold (0.7 V, normalized)
//  OUT_HIGH     16'sd16384 square_wave level while output high
//  OUT_LOW      16'sd0     square_wave level while output low
//  CV_MIN       16'sd1024  lower clamp for v_control (only used with ASTABLE555_CV_CLAMP_EN)
// PORTS
//  clk           in   1   system clock
//  I_RSTn        in   1   reset, asynchronous, active-low
//  audio_clk_en  in   1   one-cycle sample strobe; all state advances only when high
//  walk_en       in   16  signed, normalized 555 reset pin (16384 = VCC = 5 V)
//  v_control     in   16  signed, normalized control-voltage pin (upper threshold)
//  square_wave   out  16  signed, normalized 555 output
//  vcap          out  16  signed, normalized timing-capacitor voltage (debug/monitor)
// BEHAVIOUR
//  - Number format: all ports normalized Q2.14 (16384 = 5 V).
//    - Internal vc is 18-bit signed in the same format; products are 35-bit, then >>>16.
//    - Saturate vcap to 16 bits.
//  - Thresholds: th_hi = cv; th_lo = cv >>> 1 (arithmetic). Here cv is v_control, clamped if the macro is enabled.
//  - RC step, evaluated only on enables:
//    - charging:    vc_next = vc + (((16384 - vc) * K_CHARGE) >>> 16)
//    - discharging: vc_next = vc - ((vc * K_DISCHARGE) >>> 16)
//  - FSM states: HOLD, CHARGE, DISCHARGE. The evaluation below happens only when audio_clk_en = 1.
//    - Any state with walk_en < WALK_TH: go to HOLD and use the discharge step. The reset pin wins over everything.
//    - HOLD with walk_en >= WALK_TH: go to CHARGE. vc is not stepped on this sample.
//    - CHARGE: apply the charge step. If vc_next >= th_hi, go to DISCHARGE.
//    - DISCHARGE: apply the discharge step. If vc_next <= th_lo, go to CHARGE.
//    - Threshold compares use vc_next, so a crossing changes state on the same sample it happens.
//  - Output: square_wave is registered and updated in the same clk as the state.
//    - OUT_HIGH in CHARGE, OUT_LOW in HOLD and DISCHARGE.
//    - Latency: 1 clk from the enable edge. No change on non-enable cycles.
//  - v_control moves mid-cycle: compare against the current value only, with no hysteresis latch.
//    - If th_lo rises above vc while in DISCHARGE, switch to CHARGE on the next enable.
//  - Reset (async, any time, including mid-cycle): state = HOLD, vc = 0, square_wave = OUT_LOW, vcap = 0.
//    - Reset deassertion is synchronized by the parent.
//  - audio_clk_en held high for consecutive clks: one step per clk is legal.
// CONFIGURATION
//  - ASTABLE555_CV_CLAMP_EN defined: cv = min(max(v_control, CV_MIN), 16383). Oscillation is guaranteed for any input.
//  - Not defined: cv = v_control unchanged.
//    - If v_control <= 0, the block reaches DISCHARGE and stays there. square_wave sticks at OUT_LOW; this is faithful, not an error.
// STRUCTURE
//  - discrete_pkg:
//    - Q14 constants: VCC_NORM = 16384, Q14_ONE, sample width typedef sample_t (logic signed [15:0]).
//    - State enum astable_state_e {HOLD, CHARGE, DISCHARGE}.
//    - Saturating 18-to-16 function sat16.
//  - Sub-module rc_exp_step: combinational vc_next = vc + (((target - vc) * k) >>> 16).
//    - Ports: vc, target, k, vc_next.
//    - Instantiated once; target and k are muxed by state.
//  - Top holds the FSM, vc register, output register and threshold/clamp logic.
// TESTING
//  1. Reset: assert I_RSTn = 0 mid-CHARGE -> same cycle square_wave = 0, vcap = 0, state = HOLD.
//  2. Oscillation: K_CHARGE = K_DISCHARGE = 32768, walk_en = 16384, v_control = 10923.
//     -> enables: HOLD -> CHARGE (out 16384).
//     -> vc 8192, then 12288 -> DISCHARGE (out 0).
//     -> vc 6144, then 3072 -> CHARGE (out 16384). Period repeats.
//  3. Walk gate: in CHARGE, drop walk_en to 1000 -> next enable out 0, vc halves each enable.
//     -> raise walk_en to 16384 -> next enable out 16384, vc unchanged on that sample.
//  4. CV step: in DISCHARGE at vc = 6144, raise v_control to 16000 (th_lo = 8000) -> next enable CHARGE, out 16384.
//  5. Clamp: v_control = -100 with ASTABLE555_CV_CLAMP_EN -> oscillates between th_hi 1024 and th_lo 512.
//     -> without the macro: DISCHARGE reached and held, out 0 forever.
//  6. No enable: audio_clk_en = 0 for 1000 clks -> square_wave and vcap constant.

Source files
------------

// File: rtl/discrete_pkg.sv
// Shared definitions for the discrete audio models: Q2.14 sample format
// (16384 = 5 V), the 555 astable state encoding and an 18-to-16 bit saturator.
package discrete_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [17:0] vc_t;

    localparam vc_t     VCC_NORM = 18'sd16384;
    localparam sample_t Q14_ONE  = 16'sd16384;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        CHARGE    = 2'd1,
        DISCHARGE = 2'd2
    } astable_state_e;

    // Clip an 18-bit internal value to the 16-bit port range.
    function automatic sample_t sat16(input vc_t x);
        if (x > 18'sd32767)
            return 16'sd32767;
        else if (x < -18'sd32768)
            return -16'sd32768;
        else
            return sample_t'(x);
    endfunction

endpackage

// File: rtl/astable555_oscillator_if.sv
// Sample-rate signal bundle of the 555 astable.
// Strobe semantics: audio_clk_en is a one-cycle sample strobe from the master;
// the slave advances exactly once per clk in which it is high and never stalls
// the master. square_wave, vcap and state change only one clk after a strobe.
interface astable555_oscillator_if;

    logic                          audio_clk_en;
    discrete_pkg::sample_t         walk_en;
    discrete_pkg::sample_t         v_control;
    discrete_pkg::sample_t         square_wave;
    discrete_pkg::sample_t         vcap;
    discrete_pkg::astable_state_e  state;

    modport master (
        output audio_clk_en, walk_en, v_control,
        input  square_wave, vcap, state
    );

    modport slave (
        input  audio_clk_en, walk_en, v_control,
        output square_wave, vcap, state
    );

endinterface

// File: rtl/rc_exp_step.sv
// One first-order RC step of the timing capacitor toward a target voltage.
// The step magnitude |target - vc| * k / 65536 is truncated toward zero, so
// a charge step matches vc + ((VCC - vc) * k >>> 16) and a discharge step
// toward 0 matches vc - ((vc * k) >>> 16) exactly.
module rc_exp_step
    import discrete_pkg::*;
(
    input  vc_t         vc,
    input  vc_t         target,
    input  logic [15:0] k,
    output vc_t         vc_next
);

    logic        w_up;
    logic [17:0] w_mag;
    logic [33:0] w_prod;
    vc_t         w_delta;

    // Direction and magnitude of the step, then the scaled increment.
    always_comb begin
        w_up    = (target >= vc);
        w_mag   = w_up ? 18'(target - vc) : 18'(vc - target);
        w_prod  = {16'd0, w_mag} * {18'd0, k};
        w_delta = vc_t'(w_prod >> 16);
        vc_next = w_up ? (vc + w_delta) : (vc - w_delta);
    end

endmodule

// File: rtl/astable555_oscillator.sv
// Behavioural discrete model of a 555 astable, advanced once per audio_clk_en.
// Upper threshold is the control-voltage pin, lower threshold half of it.
// Optional build macro ASTABLE555_CV_CLAMP_EN clamps v_control into
// [1024, 16383] so oscillation is guaranteed for any input; without it a
// non-positive v_control parks the block in DISCHARGE with the output low.
module astable555_oscillator
    import discrete_pkg::*;
#(
    parameter logic [15:0] K_CHARGE    = 16'd120,
    parameter logic [15:0] K_DISCHARGE = 16'd240,
    parameter sample_t     WALK_TH     = 16'sd2294,
    parameter sample_t     OUT_HIGH    = Q14_ONE,
    parameter sample_t     OUT_LOW     = 16'sd0
)(
    input  logic                          clk,
    input  logic                          I_RSTn,
    astable555_oscillator_if.slave        bus
);

    astable_state_e r_state;
    vc_t            r_vc;
    sample_t        r_square;
    sample_t        r_vcap;

    sample_t        w_cv;
    vc_t            w_th_hi;
    vc_t            w_th_lo;
    logic           w_gate;
    logic           w_charging;
    vc_t            w_target;
    logic [15:0]    w_k;
    vc_t            w_vc_next;

`ifdef ASTABLE555_CV_CLAMP_EN
    localparam sample_t CV_MIN = 16'sd1024;
    localparam sample_t CV_MAX = 16'sd16383;

    // Clamp the control voltage so both thresholds stay reachable.
    always_comb begin
        if (bus.v_control < CV_MIN)
            w_cv = CV_MIN;
        else if (bus.v_control > CV_MAX)
            w_cv = CV_MAX;
        else
            w_cv = bus.v_control;
    end
`else
    // Control voltage used as-is.
    always_comb begin
        w_cv = bus.v_control;
    end
`endif

    // Thresholds, reset-pin gate and RC direction select.
    always_comb begin
        w_th_hi    = vc_t'(w_cv);
        w_th_lo    = vc_t'(w_cv >>> 1);
        w_gate     = (bus.walk_en < WALK_TH);
        w_charging = (r_state == CHARGE) && !w_gate;
        w_target   = w_charging ? VCC_NORM : 18'sd0;
        w_k        = w_charging ? K_CHARGE : K_DISCHARGE;
    end

    rc_exp_step u_rc_step (
        .vc      (r_vc),
        .target  (w_target),
        .k       (w_k),
        .vc_next (w_vc_next)
    );

    // Astable FSM with capacitor and output registers, stepped on each strobe.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_state  <= HOLD;
            r_vc     <= '0;
            r_square <= OUT_LOW;
            r_vcap   <= '0;
        end else if (bus.audio_clk_en) begin
            if (w_gate) begin
                r_state  <= HOLD;
                r_vc     <= w_vc_next;
                r_vcap   <= sat16(w_vc_next);
                r_square <= OUT_LOW;
            end else begin
                case (r_state)
                    HOLD: begin
                        r_state  <= CHARGE;
                        r_square <= OUT_HIGH;
                    end
                    CHARGE: begin
                        r_vc   <= w_vc_next;
                        r_vcap <= sat16(w_vc_next);
                        if (w_vc_next >= w_th_hi) begin
                            r_state  <= DISCHARGE;
                            r_square <= OUT_LOW;
                        end else begin
                            r_square <= OUT_HIGH;
                        end
                    end
                    DISCHARGE: begin
                        r_vc   <= w_vc_next;
                        r_vcap <= sat16(w_vc_next);
                        if (w_vc_next <= w_th_lo) begin
                            r_state  <= CHARGE;
                            r_square <= OUT_HIGH;
                        end else begin
                            r_square <= OUT_LOW;
                        end
                    end
                    default: begin
                        r_state  <= HOLD;
                        r_square <= OUT_LOW;
                    end
                endcase
            end
        end
    end

    assign bus.state       = r_state;
    assign bus.square_wave = r_square;
    assign bus.vcap        = r_vcap;

endmodule

// File: tb/tb_astable555_oscillator.sv
// Directed bench for astable555_oscillator with K_CHARGE = K_DISCHARGE = 32768
// (every RC step covers half the remaining distance), so all expected values
// below are hand-computed halvings. Build with ASTABLE555_CV_CLAMP_EN to
// exercise the clamped control-voltage path instead of the parked one.
module tb_astable555_oscillator;
    import discrete_pkg::*;

    logic clk;
    logic I_RSTn;
    int   n_tests;
    int   n_fail;

    astable555_oscillator_if bus();

    astable555_oscillator #(
        .K_CHARGE    (16'd32768),
        .K_DISCHARGE (16'd32768)
    ) dut (
        .clk    (clk),
        .I_RSTn (I_RSTn),
        .bus    (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One strobe; outputs sampled 1 time unit after the active edge.
    task automatic pulse();
        @(negedge clk);
        bus.audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        bus.audio_clk_en = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int st, input int sq, input int vc);
        check({tag, ".state"}, int'(bus.state), st);
        check({tag, ".square"}, int'(bus.square_wave), sq);
        check({tag, ".vcap"}, int'(bus.vcap), vc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        I_RSTn = 1'b0;
        repeat (3) @(negedge clk);
        I_RSTn = 1'b1;
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        I_RSTn           = 1'b0;
        bus.audio_clk_en = 1'b0;
        bus.walk_en      = 16'sd16384;
        bus.v_control    = 16'sd10923;

        // Reset state
        repeat (3) @(negedge clk);
        expect_out("reset", int'(HOLD), 0, 0);
        I_RSTn = 1'b1;

        // Oscillation: th_hi 10923, th_lo 5461
        pulse(); expect_out("osc_hold_to_charge", int'(CHARGE), 16384, 0);
        pulse(); expect_out("osc_c1", int'(CHARGE), 16384, 8192);
        pulse(); expect_out("osc_c2", int'(DISCHARGE), 0, 12288);
        pulse(); expect_out("osc_d1", int'(DISCHARGE), 0, 6144);
        pulse(); expect_out("osc_d2", int'(CHARGE), 16384, 3072);
        pulse(); expect_out("osc_c3", int'(CHARGE), 16384, 9728);
        pulse(); expect_out("osc_c4", int'(DISCHARGE), 0, 13056);

        // No enable for 1000 clocks: outputs frozen
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (i % 100 == 99) expect_out("noen", int'(DISCHARGE), 0, 13056);
        end

        // CV step: th_lo jumps to 8000 while discharging
        pulse(); expect_out("cv_d1", int'(DISCHARGE), 0, 6528);
        bus.v_control = 16'sd16000;
        pulse(); expect_out("cv_step", int'(CHARGE), 16384, 3264);
        bus.v_control = 16'sd10923;

        // Walk gate
        pulse(); expect_out("walk_c", int'(CHARGE), 16384, 9824);
        bus.walk_en = 16'sd1000;
        pulse(); expect_out("walk_hold1", int'(HOLD), 0, 4912);
        pulse(); expect_out("walk_hold2", int'(HOLD), 0, 2456);
        pulse(); expect_out("walk_hold3", int'(HOLD), 0, 1228);
        bus.walk_en = 16'sd16384;
        pulse(); expect_out("walk_release", int'(CHARGE), 16384, 1228);
        pulse(); expect_out("walk_c2", int'(CHARGE), 16384, 8806);

        // Reset-pin threshold boundary: 2293 gates, 2294 does not
        bus.walk_en = 16'sd2293;
        pulse(); expect_out("walk_th_below", int'(HOLD), 0, 4403);
        bus.walk_en = 16'sd2294;
        pulse(); expect_out("walk_th_equal", int'(CHARGE), 16384, 4403);
        bus.walk_en = 16'sd16384;

        // Asynchronous reset between clock edges while charging
        @(negedge clk);
        #2;
        I_RSTn = 1'b0;
        #1;
        expect_out("async_reset", int'(HOLD), 0, 0);
        @(negedge clk);
        I_RSTn = 1'b1;

        // Strobe held high for consecutive clocks: one step per clock
        @(negedge clk);
        bus.audio_clk_en = 1'b1;
        @(posedge clk); #1; expect_out("burst1", int'(CHARGE), 16384, 0);
        @(posedge clk); #1; expect_out("burst2", int'(CHARGE), 16384, 8192);
        @(posedge clk); #1; expect_out("burst3", int'(DISCHARGE), 0, 12288);
        bus.audio_clk_en = 1'b0;

        // Negative control voltage
        do_reset();
        bus.v_control = -16'sd100;
        pulse(); expect_out("neg_cv_p1", int'(CHARGE), 16384, 0);
        pulse(); expect_out("neg_cv_p2", int'(DISCHARGE), 0, 8192);
`ifdef ASTABLE555_CV_CLAMP_EN
        // Clamped: th_hi 1024, th_lo 512
        pulse(); expect_out("clamp_d1", int'(DISCHARGE), 0, 4096);
        pulse(); expect_out("clamp_d2", int'(DISCHARGE), 0, 2048);
        pulse(); expect_out("clamp_d3", int'(DISCHARGE), 0, 1024);
        pulse(); expect_out("clamp_lo", int'(CHARGE), 16384, 512);
        pulse(); expect_out("clamp_hi", int'(DISCHARGE), 0, 8448);
`else
        // Unclamped: parked in DISCHARGE, vcap decays to 1 and sticks
        repeat (30) pulse();
        expect_out("neg_cv_parked", int'(DISCHARGE), 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
